// File: rtl/board_mem_mc_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared types and default geometry for the multi-board game memory.
//   cell_t      : contents of one board cell
//   clr_state_t : clear sequencer states
//   width_of()  : select/index width helper, never narrower than 1 bit
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int DEF_BOARDS       = 2;
    localparam int DEF_X_SIZE       = 12;
    localparam int DEF_Y_SIZE       = 12;
    localparam int DEF_X_ADDR_WIDTH = 4;
    localparam int DEF_Y_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH   = 2;

    typedef enum logic [DEF_DATA_WIDTH-1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        MISS  = 2'd2,
        HIT   = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        CLEAR
    } clr_state_t;

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_mem_mc_if.sv
// -----------------------------------------------------------------------------
// board_mem_mc_if
// Bus between the game-logic writer / renderer reader (master) and the board
// memory (slave).
//   wr_en/wr_board/wr_addr/wr_data : write port, addr = {x, y}
//   rd_en/rd_board/rd_addr         : read request, addr = {x, y}
//   rd_data/rd_valid/rd_err        : registered read response
//   clear_req/clear_board          : one-board clear request pulse
//   clear_busy                     : clear sequencer active
// -----------------------------------------------------------------------------
interface board_mem_mc_if
    import board_pkg::*;
#(
    parameter int BOARD_WIDTH = width_of(DEF_BOARDS),
    parameter int ADDR_WIDTH  = DEF_X_ADDR_WIDTH + DEF_Y_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH
);
    logic                   wr_en;
    logic [BOARD_WIDTH-1:0] wr_board;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_en;
    logic [BOARD_WIDTH-1:0] rd_board;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   rd_err;
    logic                   clear_req;
    logic [BOARD_WIDTH-1:0] clear_board;
    logic                   clear_busy;

    modport master (
        output wr_en, wr_board, wr_addr, wr_data,
        output rd_en, rd_board, rd_addr,
        output clear_req, clear_board,
        input  rd_data, rd_valid, rd_err, clear_busy
    );

    modport slave (
        input  wr_en, wr_board, wr_addr, wr_data,
        input  rd_en, rd_board, rd_addr,
        input  clear_req, clear_board,
        output rd_data, rd_valid, rd_err, clear_busy
    );
endinterface

// File: rtl/board_mem_mc_clear_seq.sv
// -----------------------------------------------------------------------------
// board_clear_seq
// Clear sequencer: walks linear cell indices, one clear write per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   clear_req/clear_board: request to clear one board (ignored while busy)
//   seq_we/seq_index     : RAM write strobe and linear cell index
//   seq_board            : board being cleared in CLEAR
//   seq_init             : whole memory is being initialised
//   busy                 : sequencer active
//
// state | meaning
// ------+-----------------------------------------------------------
// INIT  | after reset, clear every cell of every board
// IDLE  | waiting for a clear request
// CLEAR | clearing the cells of the latched board only
// -----------------------------------------------------------------------------
module board_clear_seq
    import board_pkg::*;
#(
    parameter int BOARDS      = DEF_BOARDS,
    parameter int CELLS       = DEF_X_SIZE * DEF_Y_SIZE,
    parameter int BOARD_WIDTH = width_of(BOARDS),
    parameter int IDX_W       = width_of(BOARDS * CELLS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_req,
    input  logic [BOARD_WIDTH-1:0] clear_board,
    output logic                   seq_we,
    output logic [IDX_W-1:0]       seq_index,
    output logic [BOARD_WIDTH-1:0] seq_board,
    output logic                   seq_init,
    output logic                   busy
);
    localparam int TOTAL = BOARDS * CELLS;

    clr_state_t       state;
    logic [IDX_W-1:0] last_index;

    // Every busy cycle is a clear write.
    assign seq_we = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            seq_index  <= '0;
            last_index <= IDX_W'(TOTAL - 1);
            seq_board  <= '0;
            seq_init   <= 1'b1;
            busy       <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req && (int'(clear_board) < BOARDS)) begin
                        state      <= CLEAR;
                        seq_board  <= clear_board;
                        seq_index  <= IDX_W'(int'(clear_board) * CELLS);
                        last_index <= IDX_W'(int'(clear_board) * CELLS + CELLS - 1);
                        busy       <= 1'b1;
                    end
                end
                INIT, CLEAR: begin
                    // Stop on the real last cell, not the power-of-two bound.
                    if (seq_index == last_index) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        seq_init <= 1'b0;
                    end else begin
                        seq_index <= seq_index + IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/board_mem_mc.sv
// -----------------------------------------------------------------------------
// board_mem_mc
// BOARDS independent X_SIZE x Y_SIZE grids in one block RAM, with a
// registered read port, bounds checking and a hardware clear sequencer.
//   clk  : system clock
//   rst  : synchronous active-high reset (starts whole-memory init)
//   bus  : board_mem_mc_if slave (write port, read port, clear control)
// -----------------------------------------------------------------------------
module board_mem_mc
    import board_pkg::*;
#(
    parameter int BOARDS       = DEF_BOARDS,
    parameter int X_SIZE       = DEF_X_SIZE,
    parameter int Y_SIZE       = DEF_Y_SIZE,
    parameter int X_ADDR_WIDTH = DEF_X_ADDR_WIDTH,
    parameter int Y_ADDR_WIDTH = DEF_Y_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int BOARD_WIDTH  = width_of(BOARDS)
) (
    input  logic           clk,
    input  logic           rst,
    board_mem_mc_if.slave  bus
);
    localparam int ADDR_WIDTH = X_ADDR_WIDTH + Y_ADDR_WIDTH;
    localparam int CELLS      = X_SIZE * Y_SIZE;
    localparam int TOTAL      = BOARDS * CELLS;
    localparam int IDX_W      = width_of(TOTAL);

    function automatic logic out_of_range(input logic [BOARD_WIDTH-1:0] b,
                                          input logic [ADDR_WIDTH-1:0]  a);
        logic [X_ADDR_WIDTH-1:0] x;
        logic [Y_ADDR_WIDTH-1:0] y;
        x = a[ADDR_WIDTH-1:Y_ADDR_WIDTH];
        y = a[Y_ADDR_WIDTH-1:0];
        return (int'(x) >= X_SIZE) || (int'(y) >= Y_SIZE) || (int'(b) >= BOARDS);
    endfunction

    // Only meaningful for in-range requests; out-of-range ones may alias.
    function automatic logic [IDX_W-1:0] linear_index(input logic [BOARD_WIDTH-1:0] b,
                                                      input logic [ADDR_WIDTH-1:0]  a);
        logic [X_ADDR_WIDTH-1:0] x;
        logic [Y_ADDR_WIDTH-1:0] y;
        x = a[ADDR_WIDTH-1:Y_ADDR_WIDTH];
        y = a[Y_ADDR_WIDTH-1:0];
        return IDX_W'((int'(b) * X_SIZE + int'(x)) * Y_SIZE + int'(y));
    endfunction

    logic                   seq_we;
    logic [IDX_W-1:0]       seq_index;
    logic [BOARD_WIDTH-1:0] seq_board;
    logic                   seq_init;
    logic                   seq_busy;

    logic                   wr_oor;
    logic                   rd_oor;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   rd_cleared;

    board_clear_seq #(
        .BOARDS      (BOARDS),
        .CELLS       (CELLS),
        .BOARD_WIDTH (BOARD_WIDTH),
        .IDX_W       (IDX_W)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (bus.clear_req),
        .clear_board (bus.clear_board),
        .seq_we      (seq_we),
        .seq_index   (seq_index),
        .seq_board   (seq_board),
        .seq_init    (seq_init),
        .busy        (seq_busy)
    );

    assign bus.clear_busy = seq_busy;

    assign wr_oor = out_of_range(bus.wr_board, bus.wr_addr);
    assign rd_oor = out_of_range(bus.rd_board, bus.rd_addr);
    assign wr_idx = linear_index(bus.wr_board, bus.wr_addr);
    assign rd_idx = linear_index(bus.rd_board, bus.rd_addr);

    // A board under clear reads as cleared even where the walk has not
    // reached yet; during init that holds for every board.
    assign rd_cleared = seq_init || (seq_busy && (bus.rd_board == seq_board));

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] ram [TOTAL];

    // seq_we is high for the whole busy window, so it also blocks the
    // external writer while a clear is running.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            ram[seq_index] <= CLEAR_VALUE;
        end else if (bus.wr_en && !wr_oor) begin
            ram[wr_idx] <= bus.wr_data;
        end
    end

    // Read-first: the RAM read samples the value before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data  <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_err   <= 1'b0;
        end else begin
            bus.rd_valid <= bus.rd_en;
            bus.rd_err   <= bus.rd_en && rd_oor;
            if (bus.rd_en) begin
                if (rd_oor) begin
                    bus.rd_data <= '0;
                end else if (rd_cleared) begin
                    bus.rd_data <= CLEAR_VALUE;
                end else begin
                    bus.rd_data <= ram[rd_idx];
                end
            end
        end
    end
endmodule

// File: doc/board_mem_mc.md
Name: board_mem_mc

Overview:
- Multi-board, single-clock successor to the game-board memory.
- Holds BOARDS independent X_SIZE x Y_SIZE grids of DATA_WIDTH-bit cells: player and enemy boards in one block RAM.
- Adds a registered read port with a valid flag, bounds checking, and a hardware clear sequencer that runs automatically after reset and on request.
- Sits between the game-logic FSM (writer) and the VGA board renderer (reader).

Parameters:
- BOARDS, 2, number of independent boards.
- X_SIZE, 12, columns per board.
- Y_SIZE, 12, rows per board.
- X_ADDR_WIDTH, 4, x address bits; requires 2**X_ADDR_WIDTH >= X_SIZE.
- Y_ADDR_WIDTH, 4, y address bits; requires 2**Y_ADDR_WIDTH >= Y_SIZE.
- DATA_WIDTH, 2, cell width.
- CLEAR_VALUE, 0, value written by the clear sequencer.
- BOARD_WIDTH, $clog2(BOARDS) (min 1), board select width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_board  in  BOARD_WIDTH  target board.
- wr_addr  in  X_ADDR_WIDTH+Y_ADDR_WIDTH  {x, y}; x in the upper bits.
- wr_data  in  DATA_WIDTH  cell value.
- rd_en  in  1  read strobe.
- rd_board  in  BOARD_WIDTH  source board.
- rd_addr  in  X_ADDR_WIDTH+Y_ADDR_WIDTH  {x, y}.
- rd_data  out  DATA_WIDTH  read result.
- rd_valid  out  1  rd_data valid this cycle.
- rd_err  out  1  accompanying read was out of range.
- clear_req  in  1  request clear of one board (single-cycle pulse).
- clear_board  in  BOARD_WIDTH  board to clear.
- clear_busy  out  1  clear sequencer active.

Behaviour:
Reset:
- rst=1 forces rd_data=0, rd_valid=0, rd_err=0, clear_busy=1 (from the next edge) and FSM state INIT.
- RAM contents are not reset directly; INIT overwrites them.
- rst asserted mid-clear aborts that clear and restarts INIT from cell 0 of board 0.

Address decode:
- A request is out of range if x >= X_SIZE, y >= Y_SIZE, or board >= BOARDS.
- Linear index = (board*X_SIZE + x)*Y_SIZE + y, unsigned, sized to $clog2(BOARDS*X_SIZE*Y_SIZE).

Write port:
- Write occurs at the clk edge where wr_en=1.
- Out-of-range writes are dropped silently.
- While clear_busy=1, all external writes are dropped.

Read port:
- Latency 1: rd_en at edge N gives rd_valid=1 with rd_data in cycle N+1. rd_valid=0 otherwise, and rd_data holds its last value.
- Out of range: rd_data=0 and rd_err=1 with the valid; rd_err=0 otherwise.
- Read and write to the same cell in the same cycle are read-first: the old value is returned.
- Reads are allowed during clear. A read of the board currently being cleared returns CLEAR_VALUE regardless of sequencer progress.

Clear FSM (states IDLE, INIT, CLEAR):
- INIT: counter walks all BOARDS*X_SIZE*Y_SIZE cells, one write of CLEAR_VALUE per cycle. After the last cell it goes to IDLE; clear_busy=1 for exactly BOARDS*X_SIZE*Y_SIZE cycles.
- IDLE: clear_req=1 with clear_board < BOARDS goes to CLEAR and latches the board. A clear_req for an out-of-range board is ignored. clear_busy=0 in IDLE.
- CLEAR: walks X_SIZE*Y_SIZE cells of the latched board, then returns to IDLE; clear_busy=1 for exactly X_SIZE*Y_SIZE cycles.
- clear_req while busy is ignored; it is not queued.
- clear_req and wr_en in the same IDLE cycle: the write completes and the clear starts next cycle.
- Counter wrap: the final index is X_SIZE*Y_SIZE-1 (or the total minus 1 in INIT), never the power-of-two bound.

RAM:
- Single array with ram_style block.
- One write port, muxed between the sequencer and the external writer; the sequencer has priority.
- One read port.

Decomposition:
- Package board_pkg:
  - cell_t enum {EMPTY=0, SHIP=1, MISS=2, HIT=3} of DATA_WIDTH bits.
  - Default X_SIZE, Y_SIZE, X_ADDR_WIDTH, Y_ADDR_WIDTH, BOARDS.
  - clr_state_t enum {IDLE, INIT, CLEAR}.
- One sub-module, board_clear_seq: FSM plus cell counter. Outputs seq_we, seq_index, seq_board and busy.
- The top level holds the RAM, address decode, write mux and read register.

Test Plan (default parameters):
- Reset release: clear_busy=1 for 288 cycles, then 0. Every read of all 288 cells returns 0 with rd_err=0.
- Write board 1, {x=3, y=5}, data 2; rd_en on the same address the next cycle: rd_valid=1 and rd_data=2 one cycle after rd_en. Board 0 {3,5} still reads 0.
- Write {x=12, y=0} with data 3, then read {x=12, y=0}: RAM unchanged, rd_data=0, rd_err=1, rd_valid=1. Board 2 gives the same result.
- Fill board 0 and board 1 with 1s, then clear_req on board 0:
  - clear_busy=1 for 144 cycles.
  - Reads of board 0 during busy return 0.
  - Afterwards board 0 is all 0 and board 1 is all 1.
  - Writes issued during busy are lost.
- Simultaneous write of 3 and read at the same cell holding 1: read returns 1, and the next read returns 3.
- clear_req during INIT is ignored; rst pulse at cycle 100 of a CLEAR restarts INIT with a 288-cycle busy.
